// File: rtl/pool_sched.sv
// pool_sched: reorders a raster activation stream into 2x2 pooling windows.
// Optional POOL_SCHED_ERR_EN adds err_o for ignored starts and act_last_i checks.
module pool_sched #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    parameter int MAX_WIDTH     = 32,
    parameter int DIM_WIDTH     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [DIM_WIDTH-1:0]     cfg_width_i,
    input  logic [DIM_WIDTH-1:0]     cfg_height_i,
    input  logic                     act_valid_i,
    output logic                     act_ready_o,
    input  logic [DATA_WIDTH-1:0]    act_data_i,
    input  logic                     act_last_i,
    output logic                     pool_valid_o,
    output logic [DATA_WIDTH-1:0]    pool_data_o,
    output logic [ADDRESS_WIDTH-1:0] pool_addr_o,
    output logic                     pool_last_o,
    output logic                     busy_o,
    output logic                     done_o
`ifdef POOL_SCHED_ERR_EN
    ,
    output logic                     err_o
`endif
);

    localparam int LB_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef logic [DIM_WIDTH-1:0]     dim_t;
    typedef logic [DATA_WIDTH-1:0]    data_t;
    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
    typedef logic [LB_AW-1:0]         lb_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW,
        EMIT,
        DONE
    } state_t;

    localparam dim_t ONE = dim_t'(1);

    state_t     state_q;
    dim_t       w_q;
    dim_t       h_q;
    dim_t       row_q;
    dim_t       col_q;
    logic [1:0] beat_q;
    data_t      hold_q;
    data_t      cur_q;
    data_t      line_buf [MAX_WIDTH];

    logic       xfer;
    logic       cfg_ok;
    logic       col_last;
    logic       row_last;
    logic [1:0] nb;
    addr_t      w_a;
    addr_t      pix_a;
    data_t      win_data;
    addr_t      win_addr;
    logic       win_last;

    assign xfer     = act_valid_i && act_ready_o;
    assign col_last = (col_q == w_q - ONE);
    assign row_last = (row_q == h_q - ONE);

    assign cfg_ok = !cfg_width_i[0] && !cfg_height_i[0]
                 && (cfg_width_i >= dim_t'(2))
                 && (int'(cfg_width_i) <= MAX_WIDTH)
                 && (cfg_height_i >= dim_t'(2));

    // Beat to present next: 0 on the entering transfer, then count up.
    assign nb = (state_q == EMIT) ? beat_q + 2'd1 : 2'd0;

    assign w_a   = addr_t'(w_q);
    assign pix_a = addr_t'(row_q) * w_a + addr_t'(col_q);

    always_comb begin
        win_data = '0;
        win_addr = '0;
        case (nb)
            2'd0: begin
                win_data = line_buf[lb_idx_t'(col_q - ONE)];
                win_addr = pix_a - w_a - addr_t'(1);
            end
            2'd1: begin
                win_data = line_buf[lb_idx_t'(col_q)];
                win_addr = pix_a - w_a;
            end
            2'd2: begin
                win_data = hold_q;
                win_addr = pix_a - addr_t'(1);
            end
            default: begin
                win_data = cur_q;
                win_addr = pix_a;
            end
        endcase
    end

    assign win_last = (nb == 2'd3) && row_last && col_last;

`ifdef POOL_SCHED_ERR_EN
    logic is_final;
    assign is_final = (state_q == ODD_ROW) && row_last && col_last;
`else
    logic unused_last;
    assign unused_last = act_last_i;
`endif

    always_ff @(posedge clk) begin
        if (state_q == EVEN_ROW && xfer) begin
            line_buf[lb_idx_t'(col_q)] <= act_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            w_q          <= '0;
            h_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            beat_q       <= '0;
            hold_q       <= '0;
            cur_q        <= '0;
            act_ready_o  <= 1'b0;
            pool_valid_o <= 1'b0;
            pool_data_o  <= '0;
            pool_addr_o  <= '0;
            pool_last_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
`ifdef POOL_SCHED_ERR_EN
            err_o        <= 1'b0;
`endif
        end else begin
            pool_valid_o <= 1'b0;
            pool_data_o  <= '0;
            pool_addr_o  <= '0;
            pool_last_o  <= 1'b0;
            done_o       <= 1'b0;
`ifdef POOL_SCHED_ERR_EN
            err_o        <= 1'b0;
            if (busy_o && start_i) begin
                err_o <= 1'b1;
            end
            if (xfer && (act_last_i != is_final)) begin
                err_o <= 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (start_i && cfg_ok) begin
                        w_q         <= cfg_width_i;
                        h_q         <= cfg_height_i;
                        row_q       <= '0;
                        col_q       <= '0;
                        beat_q      <= '0;
                        act_ready_o <= 1'b1;
                        busy_o      <= 1'b1;
                        state_q     <= EVEN_ROW;
                    end
`ifdef POOL_SCHED_ERR_EN
                    else if (start_i) begin
                        err_o <= 1'b1;
                    end
`endif
                end
                EVEN_ROW: begin
                    if (xfer) begin
                        if (col_last) begin
                            col_q   <= '0;
                            row_q   <= row_q + ONE;
                            state_q <= ODD_ROW;
                        end else begin
                            col_q <= col_q + ONE;
                        end
                    end
                end
                ODD_ROW: begin
                    if (xfer) begin
                        if (!col_q[0]) begin
                            hold_q <= act_data_i;
                            col_q  <= col_q + ONE;
                        end else begin
                            cur_q        <= act_data_i;
                            beat_q       <= 2'd0;
                            act_ready_o  <= 1'b0;
                            pool_valid_o <= 1'b1;
                            pool_data_o  <= win_data;
                            pool_addr_o  <= win_addr;
                            pool_last_o  <= win_last;
                            state_q      <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (beat_q == 2'd3) begin
                        if (!col_last) begin
                            col_q       <= col_q + ONE;
                            act_ready_o <= 1'b1;
                            state_q     <= ODD_ROW;
                        end else if (!row_last) begin
                            col_q       <= '0;
                            row_q       <= row_q + ONE;
                            act_ready_o <= 1'b1;
                            state_q     <= EVEN_ROW;
                        end else begin
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        beat_q       <= nb;
                        pool_valid_o <= 1'b1;
                        pool_data_o  <= win_data;
                        pool_addr_o  <= win_addr;
                        pool_last_o  <= win_last;
                    end
                end
                DONE: begin
                    row_q   <= '0;
                    col_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    act_ready_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_sched.sv
// tb_pool_sched: directed checks of window order, timing, config filtering and reset.
// Builds with or without POOL_SCHED_ERR_EN.
module tb_pool_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [5:0] cfg_width_i;
    logic [5:0] cfg_height_i;
    logic       act_valid_i;
    logic       act_ready_o;
    logic [7:0] act_data_i;
    logic       act_last_i;
    logic       pool_valid_o;
    logic [7:0] pool_data_o;
    logic [9:0] pool_addr_o;
    logic       pool_last_o;
    logic       busy_o;
    logic       done_o;
`ifdef POOL_SCHED_ERR_EN
    logic       err_o;
`endif

    int checks = 0;
    int errors = 0;

    int q_data[$];
    int q_addr[$];
    int q_last[$];
    int q_cyc[$];
    int rdy_low;
    int zero_viol;
    int done_cyc;
    int err_cnt;
    int err_cyc;
    bit timed_out;

    pool_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .act_valid_i  (act_valid_i),
        .act_ready_o  (act_ready_o),
        .act_data_i   (act_data_i),
        .act_last_i   (act_last_i),
        .pool_valid_o (pool_valid_o),
        .pool_data_o  (pool_data_o),
        .pool_addr_o  (pool_addr_o),
        .pool_last_o  (pool_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef POOL_SCHED_ERR_EN
        ,
        .err_o        (err_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit err_now();
`ifdef POOL_SCHED_ERR_EN
        return err_o;
`else
        return 1'b0;
`endif
    endfunction

    // Streams pixel indices as data and records every window beat.
    task automatic run_frame(input int w, input int h,
                             input bit toggle, input int last_idx);
        int pix;
        bit x;
        bit got;
        q_data.delete();
        q_addr.delete();
        q_last.delete();
        q_cyc.delete();
        rdy_low   = 0;
        zero_viol = 0;
        done_cyc  = -1;
        err_cnt   = 0;
        err_cyc   = -1;
        cfg_width_i  = 6'(w);
        cfg_height_i = 6'(h);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        pix = 0;
        got = 1'b0;
        for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
            act_valid_i = (pix < w * h) && (!toggle || (cyc % 2 == 0));
            act_data_i  = 8'(pix);
            act_last_i  = (pix == last_idx);
            x = act_valid_i && act_ready_o;
            if (!act_ready_o) rdy_low++;
            @(posedge clk); #1;
            if (x) pix++;
            if (pool_valid_o) begin
                q_data.push_back(int'(pool_data_o));
                q_addr.push_back(int'(pool_addr_o));
                q_last.push_back(int'(pool_last_o));
                q_cyc.push_back(cyc);
            end else if (pool_data_o != 0 || pool_addr_o != 0 || pool_last_o) begin
                zero_viol++;
            end
            if (err_now()) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (done_o) begin
                got = 1'b1;
                done_cyc = cyc;
            end
        end
        act_valid_i = 1'b0;
        act_last_i  = 1'b0;
        timed_out = !got;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        cfg_width_i = '0;
        cfg_height_i = '0;
        act_valid_i = 1'b0;
        act_data_i = '0;
        act_last_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({act_ready_o, pool_valid_o, pool_last_o, busy_o, done_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {act_ready_o, pool_valid_o, pool_last_o, busy_o, done_o});
        end
        checks++;
        if (pool_data_o !== 8'd0 || pool_addr_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_bus: got data %0d addr %0d want 0 0",
                     pool_data_o, pool_addr_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || act_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy %b ready %b want 0 0",
                     busy_o, act_ready_o);
        end
    endtask

    task automatic test_basic();
        int exp_v[8] = '{0, 1, 4, 5, 2, 3, 6, 7};
        run_frame(4, 2, 1'b0, 7);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL basic_timeout: got no done want done");
        end
        checks++;
        if (q_data.size() != 8) begin
            errors++;
            $display("FAIL basic_beats: got %0d want 8", q_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] != exp_v[i] || q_addr[i] != exp_v[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got data %0d addr %0d want %0d",
                         i, (q_data.size() > i) ? q_data[i] : -1,
                         (q_addr.size() > i) ? q_addr[i] : -1, exp_v[i]);
            end
            checks++;
            if (q_last.size() <= i || q_last[i] != ((i == 7) ? 1 : 0)) begin
                errors++;
                $display("FAIL basic_last%0d: got %0d want %0d", i,
                         (q_last.size() > i) ? q_last[i] : -1, (i == 7) ? 1 : 0);
            end
        end
        checks++;
        if (q_cyc.size() < 1 || q_cyc[0] != 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 5",
                     (q_cyc.size() > 0) ? q_cyc[0] : -1);
        end
        checks++;
        if (q_cyc.size() < 8 || done_cyc != q_cyc[7] + 1) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d want 15", done_cyc);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_in_done: got %b want 0", busy_o);
        end
        checks++;
        if (zero_viol != 0) begin
            errors++;
            $display("FAIL basic_bus_zero: got %0d want 0", zero_viol);
        end
        checks++;
        if (err_cnt != 0) begin
            errors++;
            $display("FAIL basic_err: got %0d want 0", err_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if ({done_o, busy_o, act_ready_o} !== 3'b000) begin
            errors++;
            $display("FAIL basic_after_done: got %b want 000",
                     {done_o, busy_o, act_ready_o});
        end
    endtask

    task automatic test_toggle();
        int exp_v[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        int gaps;
        int lasts;
        run_frame(4, 4, 1'b1, 15);
        checks++;
        if (timed_out || q_data.size() != 16) begin
            errors++;
            $display("FAIL toggle_beats: got %0d want 16", q_data.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q_data.size() <= i || q_data[i] != exp_v[i] || q_addr[i] != exp_v[i]) begin
                errors++;
                $display("FAIL toggle_beat%0d: got data %0d addr %0d want %0d",
                         i, (q_data.size() > i) ? q_data[i] : -1,
                         (q_addr.size() > i) ? q_addr[i] : -1, exp_v[i]);
            end
        end
        gaps = 0;
        lasts = 0;
        for (int j = 0; j < q_cyc.size() / 4; j++) begin
            if (q_cyc[4 * j + 3] - q_cyc[4 * j] != 3) gaps++;
        end
        foreach (q_last[i]) lasts += q_last[i];
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL toggle_gaps: got %0d want 0", gaps);
        end
        checks++;
        if (lasts != 1 || q_last.size() != 16 || q_last[15] != 1) begin
            errors++;
            $display("FAIL toggle_last: got count %0d want 1 on beat 15", lasts);
        end
        checks++;
        if (zero_viol != 0) begin
            errors++;
            $display("FAIL toggle_bus_zero: got %0d want 0", zero_viol);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_width();
        int exp_v[4] = '{30, 31, 62, 63};
        run_frame(32, 2, 1'b0, 63);
        checks++;
        if (timed_out || q_data.size() != 64) begin
            errors++;
            $display("FAIL maxw_beats: got %0d want 64", q_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_addr.size() != 64 || q_addr[60 + i] != exp_v[i]
                || q_data[60 + i] != exp_v[i]) begin
                errors++;
                $display("FAIL maxw_last_win%0d: got %0d want %0d", i,
                         (q_addr.size() == 64) ? q_addr[60 + i] : -1, exp_v[i]);
            end
        end
        checks++;
        if (q_addr.size() < 4 || q_addr[0] != 0 || q_addr[1] != 1
            || q_addr[2] != 32 || q_addr[3] != 33) begin
            errors++;
            $display("FAIL maxw_first_win: got %0d want 0", (q_addr.size() > 0) ? q_addr[0] : -1);
        end
        checks++;
        if (rdy_low != 64) begin
            errors++;
            $display("FAIL maxw_ready_low: got %0d want 64", rdy_low);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bad_cfg();
        int busy_seen;
        int errs;
        int ws[3] = '{3, 4, 34};
        int hs[3] = '{2, 3, 2};
        for (int k = 0; k < 3; k++) begin
            cfg_width_i  = 6'(ws[k]);
            cfg_height_i = 6'(hs[k]);
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            busy_seen = 0;
            errs = 0;
            if (err_now()) errs++;
            for (int c = 0; c < 4; c++) begin
                if (busy_o || act_ready_o) busy_seen++;
                @(posedge clk); #1;
                if (err_now()) errs++;
            end
            checks++;
            if (busy_seen != 0) begin
                errors++;
                $display("FAIL bad_cfg_idle w%0d h%0d: got %0d want 0",
                         ws[k], hs[k], busy_seen);
            end
`ifdef POOL_SCHED_ERR_EN
            checks++;
            if (errs != 1) begin
                errors++;
                $display("FAIL bad_cfg_err w%0d h%0d: got %0d want 1",
                         ws[k], hs[k], errs);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_emit();
        int pix;
        int beats;
        bit x;
        int exp_v[8] = '{0, 1, 4, 5, 2, 3, 6, 7};
        cfg_width_i  = 6'd4;
        cfg_height_i = 6'd4;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        pix = 0;
        beats = 0;
        for (int cyc = 0; cyc < 200 && beats < 3; cyc++) begin
            act_valid_i = 1'b1;
            act_data_i  = 8'(pix);
            x = act_ready_o;
            @(posedge clk); #1;
            if (x) pix++;
            if (pool_valid_o) beats++;
        end
        checks++;
        if (beats != 3) begin
            errors++;
            $display("FAIL rst_emit_reach: got %0d want 3", beats);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        act_valid_i = 1'b0;
        checks++;
        if ({act_ready_o, pool_valid_o, pool_last_o, busy_o, done_o} !== 5'b0
            || pool_data_o !== 8'd0 || pool_addr_o !== 10'd0) begin
            errors++;
            $display("FAIL rst_emit_outputs: got ctrl %b data %0d addr %0d want 0",
                     {act_ready_o, pool_valid_o, pool_last_o, busy_o, done_o},
                     pool_data_o, pool_addr_o);
        end
        @(posedge clk); #1;
        run_frame(4, 2, 1'b0, 7);
        checks++;
        if (timed_out || q_data.size() != 8) begin
            errors++;
            $display("FAIL rst_emit_reframe: got %0d want 8", q_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_addr.size() <= i || q_addr[i] != exp_v[i] || q_data[i] != exp_v[i]) begin
                errors++;
                $display("FAIL rst_emit_beat%0d: got %0d want %0d", i,
                         (q_addr.size() > i) ? q_addr[i] : -1, exp_v[i]);
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef POOL_SCHED_ERR_EN
    task automatic test_last_err();
        int exp_v[4] = '{0, 1, 2, 3};
        run_frame(2, 2, 1'b0, 2);
        checks++;
        if (err_cyc != 2 || err_cnt != 2) begin
            errors++;
            $display("FAIL last_err: got cyc %0d cnt %0d want 2 2", err_cyc, err_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_addr.size() != 4 || q_addr[i] != exp_v[i]
                || q_last[i] != ((i == 3) ? 1 : 0)) begin
                errors++;
                $display("FAIL last_err_beat%0d: got %0d want %0d", i,
                         (q_addr.size() == 4) ? q_addr[i] : -1, exp_v[i]);
            end
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_max_width();
        test_bad_cfg();
        test_reset_mid_emit();
`ifdef POOL_SCHED_ERR_EN
        test_last_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_sched.md
POOL_SCHED -- requirements
Module: pool_sched

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 8, activation/pool data width; ADDRESS_WIDTH, 10, pixel address width; MAX_WIDTH, 32, maximum feature-map width (line-buffer depth); DIM_WIDTH, 6, width of the cfg dimension ports.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, single clock; rst, in, 1, synchronous active-high reset.
REQ-003 start_i in 1 frame start pulse; cfg_width_i in DIM_WIDTH frame width W; cfg_height_i in DIM_WIDTH frame height H.
REQ-004 act_valid_i in 1; act_ready_o out 1; act_data_i in DATA_WIDTH; act_last_i in 1: raster-order activation stream, beat transferred when valid and ready are both high.
REQ-005 pool_valid_o out 1; pool_data_o out DATA_WIDTH; pool_addr_o out ADDRESS_WIDTH; pool_last_o out 1: window-ordered stream to the pooling datapath.
REQ-006 busy_o out 1 frame in progress; done_o out 1 one-cycle frame-complete pulse.

Function
REQ-007 The block SHALL reorder a raster W x H stream into 2x2 windows: per window, 4 consecutive pool_valid_o beats (r-1,c-1), (r-1,c), (r,c-1), (r,c), with r and c odd, no gap cycles.
REQ-008 The pixel address SHALL be r*W + c, truncated to ADDRESS_WIDTH bits, presented on pool_addr_o with its data.
REQ-009 Valid config: W and H even, 2 <= W <= MAX_WIDTH, H >= 2; start_i with invalid config or while busy_o is high SHALL be ignored.
REQ-010 States: IDLE, EVEN_ROW, ODD_ROW, EMIT, DONE.
REQ-011 IDLE: act_ready_o=0; valid start_i latches W, H, clears row/col counters, goes to EVEN_ROW next cycle.
REQ-012 EVEN_ROW: act_ready_o=1; each transfer writes line_buf[col]; after col W-1 go to ODD_ROW, col=0, row+1.
REQ-013 ODD_ROW: act_ready_o=1; even-col transfer loads the hold register; odd-col transfer goes to EMIT.
REQ-014 EMIT: act_ready_o=0; 2-bit beat counter 0..3 drives one window beat per cycle; first beat appears the cycle after the odd-col transfer (latency 1).
REQ-015 EMIT exit after beat 3: more columns -> ODD_ROW; row end with rows remaining -> EVEN_ROW; last window -> DONE.
REQ-016 pool_last_o SHALL be high only on beat 3 of the final window (row H-1, col W-1).
REQ-017 DONE: done_o=1 for exactly one cycle, busy_o=0 in that cycle, then IDLE.
REQ-018 busy_o SHALL be high in EVEN_ROW, ODD_ROW, EMIT; low in IDLE and DONE.
REQ-019 Outputs pool_data_o, pool_addr_o SHALL be 0 whenever pool_valid_o is 0.
REQ-020 act_valid_i low in any state SHALL stall counters without losing buffered data.

Reset
REQ-021 rst high at any clock edge, including mid-frame or mid-EMIT, SHALL force IDLE and clear all counters on that edge.
REQ-022 Reset values: act_ready_o=0, pool_valid_o=0, pool_data_o=0, pool_addr_o=0, pool_last_o=0, busy_o=0, done_o=0; line buffer contents are don't-care.

Configuration
REQ-023 Macro POOL_SCHED_ERR_EN defined: port err_o (out, 1) SHALL pulse one cycle on ignored start_i (invalid config or busy), or on act_last_i mismatch (high before final pixel, or low on final pixel); frame continues by counters.
REQ-024 Macro POOL_SCHED_ERR_EN undefined: err_o port absent, act_last_i unused, start filtering of REQ-009 unchanged.

Verification
REQ-025 W=4,H=2, data=pixel index 0..7, valid held high -> windows (0,1,4,5),(2,3,6,7), addrs same as data, pool_last_o on beat with addr 7, done_o one cycle later.
REQ-026 W=4,H=4, act_valid_i toggled 1/0 -> 4 windows, first (0,1,4,5), last (10,11,14,15), no gap inside any window.
REQ-027 W=32,H=2 -> 16 windows, last window addrs 30,31,62,63, act_ready_o low exactly 4 cycles per window.
REQ-028 W=3 start_i -> stays IDLE, busy_o=0; with POOL_SCHED_ERR_EN err_o pulses once.
REQ-029 rst asserted during EMIT beat 2 of W=4,H=4 -> next cycle all outputs 0, IDLE; new valid start runs a clean frame.
REQ-030 W=2,H=2 with act_last_i on pixel 2 (ERR_EN) -> err_o pulse, window (0,1,2,3) still emitted, pool_last_o on addr 3.
